// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse position tracker.
//   state_t      : packet FSM states (IDLE / CALC / CLAMP)
//   XSIGN..YOVF  : bit positions inside PS/2 status byte 0
//   D9_W..SUM_W  : widths of the per-axis delta / sum datapath
package mouse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CLAMP = 2'd2
    } state_t;

    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    localparam int D9_W  = 9;    // {sign, raw}
    localparam int D10_W = 10;   // after optional negation (-(-256) = +256)
    localparam int DS_W  = 13;   // after <<< 0..3
    // Sum width covers any POS_W up to 12: 4095 + 2048 still fits signed,
    // so the clamp never sees a wrapped value.
    localparam int SUM_W = 15;

    localparam logic signed [D9_W-1:0] D9_POS_SAT = 9'h0FF;  // +255
    localparam logic signed [D9_W-1:0] D9_NEG_SAT = 9'h100;  // -256

endpackage

// File: rtl/mouse_axis_clamp.sv
// One axis of the position datapath: overflow saturation, optional
// negation, speed scaling, registered sum, then clamp to 0..limit-1.
//   CLK, rst_n  : clock / internal async active-low reset
//   calc        : load the sum register (FSM in CALC)
//   ovf, d9     : overflow flag and {sign, raw} delta of the latched packet
//   invert      : negate the delta
//   shift       : speed left-shift 0..3
//   pos         : current position
//   limit       : axis extent (0 behaves as 1)
//   next_pos    : clamped position from the registered sum
module mouse_axis_clamp
    import mouse_pkg::*;
#(
    parameter int POS_W = 10
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             calc,
    input  logic             ovf,
    input  logic [D9_W-1:0]  d9,
    input  logic             invert,
    input  logic [1:0]       shift,
    input  logic [POS_W-1:0] pos,
    input  logic [POS_W-1:0] limit,
    output logic [POS_W-1:0] next_pos
);

    logic signed [D9_W-1:0]  d9_sat;
    logic signed [D10_W-1:0] d10;
    logic signed [DS_W-1:0]  scaled;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] sum_q;
    logic signed [SUM_W-1:0] lim_ext;
    logic [POS_W-1:0]        lim_m1;

    always_comb begin
        d9_sat = ovf ? (d9[D9_W-1] ? D9_NEG_SAT : D9_POS_SAT) : $signed(d9);
        d10    = D10_W'(d9_sat);
        if (invert) d10 = -d10;
        scaled = DS_W'(d10) <<< shift;
        sum    = $signed(SUM_W'({1'b0, pos})) + SUM_W'(scaled);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n)    sum_q <= '0;
        else if (calc) sum_q <= sum;
    end

    always_comb begin
        lim_m1  = (limit == '0) ? '0 : limit - POS_W'(1);
        lim_ext = SUM_W'(lim_m1);
        if (sum_q[SUM_W-1])      next_pos = '0;
        else if (sum_q > lim_ext) next_pos = lim_m1;
        else                     next_pos = sum_q[POS_W-1:0];
    end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Absolute mouse pointer tracker fed by decoded PS/2 packets.
// Accept (IDLE) -> CALC (register sums) -> CLAMP (update outputs, POS_VALID).
//   CLK, RESET        : clock, async active-low reset (release synchronised)
//   PKT_*             : packet handshake and bytes (PKT_DZ = wheel nibble)
//   SPEED_SHIFT       : delta shift, latched with the packet
//   LIMIT_LOAD/X/Y    : runtime extents, position clamped into new range
//   RECENTRE          : jump to limit/2, aborts any in-flight packet
//   POS_X/Y, BUTTONS  : registered pointer state
//   BUTTON_PRESS      : per-button rising-edge pulse
//   POS_VALID         : one-cycle update strobe
//   POS_Z             : saturating wheel accumulator, only with MOUSE_WHEEL_EN
// Build option: define MOUSE_WHEEL_EN to add the wheel accumulator.
module mouse_pos_tracker
    import mouse_pkg::*;
#(
    parameter int POS_W       = 10,
    parameter int DEF_LIMIT_X = 640,
    parameter int DEF_LIMIT_Y = 480,
    parameter int INVERT_Y    = 1,
    parameter int Z_W         = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PKT_VALID,
    output logic                  PKT_READY,
    input  logic [7:0]            PKT_STATUS,
    input  logic [7:0]            PKT_DX,
    input  logic [7:0]            PKT_DY,
    input  logic [3:0]            PKT_DZ,
    input  logic [1:0]            SPEED_SHIFT,
    input  logic                  LIMIT_LOAD,
    input  logic [POS_W-1:0]      LIMIT_X,
    input  logic [POS_W-1:0]      LIMIT_Y,
    input  logic                  RECENTRE,
    output logic [POS_W-1:0]      POS_X,
    output logic [POS_W-1:0]      POS_Y,
`ifdef MOUSE_WHEEL_EN
    output logic signed [Z_W-1:0] POS_Z,
`endif
    output logic [2:0]            BUTTONS,
    output logic [2:0]            BUTTON_PRESS,
    output logic                  POS_VALID
);

    // Assert asynchronously, release two clocks after RESET rises.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_t           state;
    logic [7:0]       pkt_status, pkt_dx, pkt_dy;
    logic [1:0]       shift_q;
    logic [POS_W-1:0] lim_x, lim_y;
    logic             rc_pend;
    logic             accept;

    logic [POS_W-1:0] nx_x, nx_y, base_x, base_y, ldl_x, ldl_y, fin_x, fin_y;
    logic [POS_W-1:0] cen_x, cen_y;
    logic             over_x, over_y;

    assign accept = (state == IDLE) && PKT_VALID && PKT_READY && !RECENTRE;

    mouse_axis_clamp #(.POS_W(POS_W)) u_axis_x (
        .CLK(CLK), .rst_n(rst_n), .calc(state == CALC),
        .ovf(pkt_status[XOVF]), .d9({pkt_status[XSIGN], pkt_dx}),
        .invert(1'b0), .shift(shift_q), .pos(POS_X), .limit(lim_x),
        .next_pos(nx_x)
    );

    mouse_axis_clamp #(.POS_W(POS_W)) u_axis_y (
        .CLK(CLK), .rst_n(rst_n), .calc(state == CALC),
        .ovf(pkt_status[YOVF]), .d9({pkt_status[YSIGN], pkt_dy}),
        .invert(INVERT_Y != 0), .shift(shift_q), .pos(POS_Y), .limit(lim_y),
        .next_pos(nx_y)
    );

    // A limit load clamps whatever position this cycle would otherwise
    // produce, including a packet result computed against the old limit.
    always_comb begin
        base_x = (state == CLAMP) ? nx_x : POS_X;
        base_y = (state == CLAMP) ? nx_y : POS_Y;
        ldl_x  = (LIMIT_X == '0) ? POS_W'(1) : LIMIT_X;
        ldl_y  = (LIMIT_Y == '0) ? POS_W'(1) : LIMIT_Y;
        over_x = LIMIT_LOAD && (base_x >= ldl_x);
        over_y = LIMIT_LOAD && (base_y >= ldl_y);
        fin_x  = over_x ? ldl_x - POS_W'(1) : base_x;
        fin_y  = over_y ? ldl_y - POS_W'(1) : base_y;
        cen_x  = (LIMIT_LOAD ? LIMIT_X : lim_x) >> 1;
        cen_y  = (LIMIT_LOAD ? LIMIT_Y : lim_y) >> 1;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            PKT_READY    <= 1'b0;
            pkt_status   <= '0;
            pkt_dx       <= '0;
            pkt_dy       <= '0;
            shift_q      <= '0;
            lim_x        <= POS_W'(DEF_LIMIT_X);
            lim_y        <= POS_W'(DEF_LIMIT_Y);
            POS_X        <= POS_W'(DEF_LIMIT_X / 2);
            POS_Y        <= POS_W'(DEF_LIMIT_Y / 2);
            BUTTONS      <= '0;
            BUTTON_PRESS <= '0;
            POS_VALID    <= 1'b0;
            rc_pend      <= 1'b0;
        end else begin
            POS_VALID    <= rc_pend;   // recentre strobe trails the move by one cycle
            BUTTON_PRESS <= '0;
            rc_pend      <= 1'b0;
            if (LIMIT_LOAD) begin
                lim_x <= LIMIT_X;
                lim_y <= LIMIT_Y;
            end
            if (RECENTRE) begin
                state     <= IDLE;
                PKT_READY <= 1'b1;
                POS_X     <= cen_x;
                POS_Y     <= cen_y;
                rc_pend   <= 1'b1;
            end else begin
                POS_X <= fin_x;
                POS_Y <= fin_y;
                if (over_x || over_y) POS_VALID <= 1'b1;
                case (state)
                    IDLE: begin
                        if (accept) begin
                            pkt_status <= PKT_STATUS;
                            pkt_dx     <= PKT_DX;
                            pkt_dy     <= PKT_DY;
                            shift_q    <= SPEED_SHIFT;
                            PKT_READY  <= 1'b0;
                            state      <= CALC;
                        end else begin
                            PKT_READY  <= 1'b1;
                        end
                    end
                    CALC: state <= CLAMP;
                    CLAMP: begin
                        BUTTONS      <= pkt_status[2:0];
                        BUTTON_PRESS <= pkt_status[2:0] & ~BUTTONS;
                        POS_VALID    <= 1'b1;
                        PKT_READY    <= 1'b1;
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef MOUSE_WHEEL_EN
    localparam logic signed [Z_W:0] Z_MAX = (Z_W+1)'(2**(Z_W-1) - 1);
    localparam logic signed [Z_W:0] Z_MIN = (Z_W+1)'(-(2**(Z_W-1)));

    logic [3:0]            pkt_dz;
    logic signed [Z_W:0]   z_sum;
    logic signed [Z_W-1:0] z_next;

    always_comb begin
        z_sum = (Z_W+1)'(POS_Z) + (Z_W+1)'($signed(pkt_dz));
        if (z_sum > Z_MAX)      z_next = Z_MAX[Z_W-1:0];
        else if (z_sum < Z_MIN) z_next = Z_MIN[Z_W-1:0];
        else                    z_next = z_sum[Z_W-1:0];
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pkt_dz <= '0;
            POS_Z  <= '0;
        end else begin
            if (accept) pkt_dz <= PKT_DZ;
            if (state == CLAMP && !RECENTRE) POS_Z <= z_next;
        end
    end

    logic unused_bits;
    assign unused_bits = pkt_status[3];
`else
    logic unused_bits;
    assign unused_bits = ^{PKT_DZ, pkt_status[3]};
`endif

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Randomised + directed bench for mouse_pos_tracker against an integer
// reference model of the pointer rules.
module tb_mouse_pos_tracker;

    localparam int POS_W = 10;
    localparam int DLX   = 640;
    localparam int DLY   = 480;
    localparam int INV_Y = 1;
    localparam int Z_W   = 8;

    logic             CLK, RESET, PKT_VALID, PKT_READY, LIMIT_LOAD, RECENTRE, POS_VALID;
    logic [7:0]       PKT_STATUS, PKT_DX, PKT_DY;
    logic [3:0]       PKT_DZ;
    logic [1:0]       SPEED_SHIFT;
    logic [POS_W-1:0] LIMIT_X, LIMIT_Y, POS_X, POS_Y;
    logic [2:0]       BUTTONS, BUTTON_PRESS;
`ifdef MOUSE_WHEEL_EN
    logic signed [Z_W-1:0] POS_Z;
`endif

    mouse_pos_tracker #(.POS_W(POS_W), .DEF_LIMIT_X(DLX), .DEF_LIMIT_Y(DLY),
                        .INVERT_Y(INV_Y), .Z_W(Z_W)) dut (
        .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .PKT_READY(PKT_READY),
        .PKT_STATUS(PKT_STATUS), .PKT_DX(PKT_DX), .PKT_DY(PKT_DY), .PKT_DZ(PKT_DZ),
        .SPEED_SHIFT(SPEED_SHIFT), .LIMIT_LOAD(LIMIT_LOAD), .LIMIT_X(LIMIT_X),
        .LIMIT_Y(LIMIT_Y), .RECENTRE(RECENTRE), .POS_X(POS_X), .POS_Y(POS_Y),
`ifdef MOUSE_WHEEL_EN
        .POS_Z(POS_Z),
`endif
        .BUTTONS(BUTTONS), .BUTTON_PRESS(BUTTON_PRESS), .POS_VALID(POS_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int mx, my, mz, lim_x, lim_y;
    logic [2:0] mbtn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pointer rule for one axis, in plain integers.
    function automatic int axis_ref(input int pos, input int raw, input bit sgn,
                                    input bit ovf, input bit inv, input int sh, input int lim);
        int d, s, l;
        if (ovf) d = sgn ? -256 : 255;
        else     d = sgn ? raw - 256 : raw;
        if (inv) d = -d;
        d = d * (1 << sh);
        l = (lim == 0) ? 1 : lim;
        s = pos + d;
        if (s < 0)     return 0;
        if (s > l - 1) return l - 1;
        return s;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (PKT_READY !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, PKT_READY, 1);
    endtask

    task automatic send_pkt(input string tag, input logic [7:0] st, input logic [7:0] dx,
                            input logic [7:0] dy, input logic [3:0] dz, input logic [1:0] sh);
        int ex, ey, ez;
        logic [2:0] ep;
        wait_ready({tag, "_rdy"});
        ex = axis_ref(mx, int'(dx), st[4], st[6], 1'b0, int'(sh), lim_x);
        ey = axis_ref(my, int'(dy), st[5], st[7], INV_Y != 0, int'(sh), lim_y);
        ep = st[2:0] & ~mbtn;
        ez = mz + int'($signed(dz));
        if (ez > 2**(Z_W-1) - 1) ez = 2**(Z_W-1) - 1;
        if (ez < -(2**(Z_W-1)))  ez = -(2**(Z_W-1));
        PKT_VALID = 1'b1; PKT_STATUS = st; PKT_DX = dx; PKT_DY = dy;
        PKT_DZ = dz; SPEED_SHIFT = sh;
        tick();
        // Scramble the bus: the DUT must work from its latched copy.
        PKT_VALID = 1'b0; PKT_STATUS = 8'($urandom); PKT_DX = 8'($urandom);
        PKT_DY = 8'($urandom); PKT_DZ = 4'($urandom); SPEED_SHIFT = 2'($urandom);
        chk({tag, "_acc"}, PKT_READY, 0);
        tick();
        chk({tag, "_v_early"}, POS_VALID, 0);
        tick();
        chk({tag, "_v"}, POS_VALID, 1);
        chk({tag, "_x"}, POS_X, ex);
        chk({tag, "_y"}, POS_Y, ey);
        chk({tag, "_btn"}, BUTTONS, st[2:0]);
        chk({tag, "_press"}, BUTTON_PRESS, ep);
`ifdef MOUSE_WHEEL_EN
        chk({tag, "_z"}, POS_Z, 8'(ez));
`endif
        tick();
        chk({tag, "_v_end"}, POS_VALID, 0);
        chk({tag, "_press_end"}, BUTTON_PRESS, 0);
        mx = ex; my = ey; mz = ez; mbtn = st[2:0];
    endtask

    task automatic recentre(input string tag);
        RECENTRE = 1'b1;
        tick();
        RECENTRE = 1'b0;
        mx = lim_x / 2; my = lim_y / 2;
        chk({tag, "_x"}, POS_X, mx);
        chk({tag, "_y"}, POS_Y, my);
        chk({tag, "_v0"}, POS_VALID, 0);
        tick();
        chk({tag, "_v1"}, POS_VALID, 1);
        tick();
        chk({tag, "_v2"}, POS_VALID, 0);
    endtask

    task automatic load_limits(input string tag, input int lx, input int ly);
        int elx, ely, ex, ey;
        elx = (lx == 0) ? 1 : lx;
        ely = (ly == 0) ? 1 : ly;
        ex = (mx >= elx) ? elx - 1 : mx;
        ey = (my >= ely) ? ely - 1 : my;
        LIMIT_LOAD = 1'b1; LIMIT_X = POS_W'(lx); LIMIT_Y = POS_W'(ly);
        tick();
        LIMIT_LOAD = 1'b0;
        chk({tag, "_x"}, POS_X, ex);
        chk({tag, "_y"}, POS_Y, ey);
        chk({tag, "_v"}, POS_VALID, (ex != mx) || (ey != my));
        mx = ex; my = ey; lim_x = lx; lim_y = ly;
        tick();
        chk({tag, "_v_end"}, POS_VALID, 0);
    endtask

    initial begin
        RESET = 1'b0; PKT_VALID = 1'b0; PKT_STATUS = '0; PKT_DX = '0; PKT_DY = '0;
        PKT_DZ = '0; SPEED_SHIFT = '0; LIMIT_LOAD = 1'b0; LIMIT_X = '0; LIMIT_Y = '0;
        RECENTRE = 1'b0;
        mx = DLX / 2; my = DLY / 2; mz = 0; lim_x = DLX; lim_y = DLY; mbtn = '0;

        // Reset state
        #23;
        chk("rst_x", POS_X, 320);
        chk("rst_y", POS_Y, 240);
        chk("rst_rdy", PKT_READY, 0);
        chk("rst_v", POS_VALID, 0);
        chk("rst_btn", BUTTONS, 0);
`ifdef MOUSE_WHEEL_EN
        chk("rst_z", POS_Z, 0);
`endif
        tick();
        RESET = 1'b1;
        wait_ready("rel_rdy");

        // Directed moves
        send_pkt("basic", 8'h00, 8'h10, 8'h05, 4'h0, 2'd0);
        chk("basic_x_abs", POS_X, 336);
        chk("basic_y_abs", POS_Y, 235);
        send_pkt("xneg_ovf", 8'h50, 8'h00, 8'h00, 4'h0, 2'd3);
        chk("xneg_abs", POS_X, 0);
        send_pkt("xpos_ovf", 8'h40, 8'h00, 8'h00, 4'h0, 2'd3);
        chk("xpos_abs", POS_X, 639);

        // Limits and recentre
        recentre("rc_def");
        load_limits("ld_small", 160, 120);
        chk("ld_abs_x", POS_X, 159);
        chk("ld_abs_y", POS_Y, 119);
        recentre("rc_small");
        chk("rc_abs_x", POS_X, 80);
        chk("rc_abs_y", POS_Y, 60);

        // Abort: recentre while the packet sits in CALC
        send_pkt("pre_abort", 8'h00, 8'd5, 8'h00, 4'h0, 2'd0);
        wait_ready("abort_rdy");
        PKT_VALID = 1'b1; PKT_STATUS = 8'h00; PKT_DX = 8'd20; PKT_DY = 8'd0; SPEED_SHIFT = 2'd0;
        tick();
        PKT_VALID = 1'b0;
        RECENTRE = 1'b1;
        tick();
        RECENTRE = 1'b0;
        mx = lim_x / 2; my = lim_y / 2;
        chk("abort_x", POS_X, mx);
        chk("abort_rdy_hi", PKT_READY, 1);
        chk("abort_v0", POS_VALID, 0);
        tick();
        chk("abort_v1", POS_VALID, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_quiet_v", POS_VALID, 0);
            chk("abort_quiet_x", POS_X, mx);
        end

        // Button edges
        send_pkt("btn1", 8'h01, 8'h00, 8'h00, 4'h0, 2'd0);
        chk("btn1_press_abs", BUTTON_PRESS, 0);
        send_pkt("btn3", 8'h03, 8'h00, 8'h00, 4'h0, 2'd0);

        // Zero limit behaves as one
        load_limits("ld_zero", 0, 1);
        send_pkt("zero_lim", 8'h00, 8'h7F, 8'h80, 4'h0, 2'd2);

        // Random traffic with periodic limit loads and recentres
        load_limits("ld_full", 1023, 700);
        for (int i = 0; i < 48; i++) begin
            if (i % 8 == 7) load_limits("rnd_ld", int'($urandom_range(0, 1023)), int'($urandom_range(1, 1023)));
            if (i % 12 == 5) recentre("rnd_rc");
            send_pkt("rnd", 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 2'($urandom));
        end

`ifdef MOUSE_WHEEL_EN
        for (int i = 0; i < 200; i++)
            send_pkt("wheel", 8'h00, 8'h00, 8'h00, 4'hF, 2'd0);
        chk("wheel_sat", POS_Z, 8'h80);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
